instr_encoder_loader: RTL
=========================

# instr_encoder_loader

Encoder and writer counterpart of the CPU control decoder. Accepts instruction requests as a class code plus register/immediate/target fields over a valid/ready handshake. Encodes each request into a 32-bit instruction word using the CPU opcode map and writes the words sequentially into instruction memory. Sits between the test/boot host and the instruction memory and loads programs before the CPU is released from reset.

## Interface
- DEPTH, 256: instruction memory capacity in words; legal range 2..65536.
- AW, 8: memory address width; must satisfy 2^AW >= DEPTH.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; enters LOAD, clears address and flags.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted on any cycle where in_valid && in_ready.
- in_kind  input  4  class: 0 R, 1 BEQ, 2 LW, 3 SW, 4 ADDI, 5 ANDI, 6 XORI, 7 SLTI, 8 J, 9 JAL, 10 JR; 11–15 illegal.
- in_rs, in_rt, in_rd  input  5 each  register fields.
- in_shamt  input  5  R-type shift amount.
- in_funct  input  6  R-type function.
- in_imm  input  32  signed immediate (I-type).
- in_target  input  26  jump target (J, JAL).
- in_last  input  1  marks the final request of the program.
- mem_we  output  1  instruction-memory write strobe.
- mem_addr  output  AW  write address.
- mem_wdata  output  32  encoded word.
- count  output  AW+1  words written since start.
- busy  output  1  high in LOAD and FLUSH.
- done  output  1  one-cycle pulse when the last word is written.
- err  output  1  sticky; set on illegal kind, immediate range violation, or overflow.

## Operation
- Opcode map, in_kind 0..10: 000000, 000001, 000010, 000011, 000100, 000101, 000110, 000111, 001000, 001001, 001010.
- R: {op, rs, rt, rd, shamt, funct}.
- BEQ, LW, SW, ADDI, SLTI: {op, rs, rt, imm[15:0]}.
  - in_imm must lie in −32768..32767; otherwise error.
- ANDI, XORI: {op, rs, rt, imm[15:0]}.
  - in_imm must lie in 0..65535; otherwise error.
- J, JAL: {op, target}.
- JR: {op, rs, 21'b0}.
- States: IDLE, LOAD, FLUSH, HALT.
  - IDLE, start → LOAD.
  - LOAD, accept with in_last → FLUSH.
  - LOAD, error → HALT.
  - FLUSH → IDLE. The last write completes in this cycle and done pulses.
  - HALT, start → LOAD.
  - start in LOAD or FLUSH restarts: any pending write is dropped, and address, count and err are cleared.
- Readiness: in_ready = (state==LOAD) && (count + pending < DEPTH). pending = 1 when a write is registered but not yet performed.
- Error on accept (illegal kind or range violation):
  - No write occurs for the request; err sets; state → HALT.
  - Words already written are kept.
- Overflow: reaching DEPTH writes without in_last sets err and → HALT.
  - Address never wraps.
- start has priority over a simultaneous in_valid; that request is not accepted.

## Timing
- Accept at edge N registers the word. During cycle N+1: mem_we=1, mem_addr=count, mem_wdata=word.
- count increments at edge N+1.
- Sustained throughput: 1 word/cycle. in_ready may stay high while a write is pending.
- done is high during the same cycle as the final mem_we.
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, count=0, busy=0, done=0, err=0, state IDLE.
- rst mid-load aborts immediately; any pending write is dropped.
- mem_wdata holds its last value when mem_we=0.

## Test plan
- ADDI rs=1 rt=2 imm=−5, in_last=1:
  - mem_we at addr 0 with 0x1022FFFB; done in the same cycle; count=1.
- Back-to-back R (rs3 rt4 rd5 funct 0x20) then J target 0x100 with in_last:
  - words 0x00642820 @0 and 0x20000100 @1 on consecutive cycles.
- ANDI imm=70000:
  - no mem_we; err=1; in_ready=0.
  - After start: err=0 and count=0.
- Illegal kind 12 after two good words:
  - count stays 2; err=1; state HALT.
- DEPTH=4, five requests with no in_last:
  - four writes at addresses 0–3; in_ready drops after the 4th accept; err=1.
- rst asserted the cycle after an accept:
  - no mem_we; all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Encodes instruction requests into 32-bit CPU words and writes them
// sequentially into instruction memory ahead of CPU release.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting requests, one registered write in flight at most
// FLUSH | final word being written, done pulses
// HALT  | stopped on error or overflow, waiting for start
module instr_encoder_loader #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_kind,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_shamt,
  input  logic [5:0]    in_funct,
  input  logic [31:0]   in_imm,
  input  logic [25:0]   in_target,
  input  logic          in_last,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [AW:0]   count,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, HALT} state_t;

  state_t      state, state_nx;
  logic [AW:0] count_q, count_nx;
  logic        pending_q, pending_nx;
  logic [31:0] wdata_q, wdata_nx;
  logic        err_q, err_nx;
  logic [31:0] word;
  logic        bad;
  logic [5:0]  op;
  logic [AW+1:0] fill;
  logic        write_now, accept;

  assign op = {2'b00, in_kind};

  always_comb begin
    word = '0;
    bad  = 1'b0;
    case (in_kind)
      4'd0: word = {op, in_rs, in_rt, in_rd, in_shamt, in_funct};
      4'd1, 4'd2, 4'd3, 4'd4, 4'd7: begin
        word = {op, in_rs, in_rt, in_imm[15:0]};
        bad  = !((&in_imm[31:15]) || (~|in_imm[31:15]));
      end
      4'd5, 4'd6: begin
        word = {op, in_rs, in_rt, in_imm[15:0]};
        bad  = |in_imm[31:16];
      end
      4'd8, 4'd9: word = {op, in_target};
      4'd10:      word = {op, in_rs, 21'b0};
      default:    bad  = 1'b1;
    endcase
  end

  // start and rst drop the in-flight write in the very cycle they are seen
  assign write_now = pending_q && !start && !rst;
  assign fill      = {1'b0, count_q} + (AW+2)'(pending_q);
  assign in_ready  = (state == LOAD) && !start && !rst && (fill < (AW+2)'(DEPTH));
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_nx   = state;
    count_nx   = count_q + (AW+1)'(write_now);
    pending_nx = 1'b0;
    wdata_nx   = wdata_q;
    err_nx     = err_q;
    if (start) begin
      state_nx = LOAD;
      count_nx = '0;
      err_nx   = 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            if (bad) begin
              err_nx   = 1'b1;
              state_nx = HALT;
            end else begin
              pending_nx = 1'b1;
              wdata_nx   = word;
              if (in_last) state_nx = FLUSH;
            end
          end else if (write_now && count_nx == (AW+1)'(DEPTH)) begin
            err_nx   = 1'b1;
            state_nx = HALT;
          end
        end
        FLUSH:   state_nx = IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count_q   <= '0;
      pending_q <= 1'b0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nx;
      count_q   <= count_nx;
      pending_q <= pending_nx;
      wdata_q   <= wdata_nx;
      err_q     <= err_nx;
    end
  end

  assign mem_we    = write_now;
  assign mem_addr  = count_q[AW-1:0];
  assign mem_wdata = wdata_q;
  assign count     = count_q;
  assign busy      = (state == LOAD) || (state == FLUSH);
  assign done      = (state == FLUSH) && write_now;
  assign err       = err_q;

endmodule
